// File: rtl/alu_pkg.sv
// Shared encodings for the ALU command sequencer: ALU selects, command opcodes, FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_TRANSFER = 4'b0000;
    localparam logic [3:0] ALU_ADD      = 4'b0001;
    localparam logic [3:0] ALU_SUBM1    = 4'b0010;
    localparam logic [3:0] ALU_SHR      = 4'b1000;
    localparam logic [3:0] ALU_SHL      = 4'b1100;

    localparam logic [2:0] OP_ADD64 = 3'b000;
    localparam logic [2:0] OP_SUB64 = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHRL  = 3'b011;
    localparam logic [2:0] OP_SHRA  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_SHIFT,
        ST_DONE
    } state_e;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHRL) || (op == OP_SHRA);
    endfunction

endpackage

// File: rtl/alu_seq_shift_cnt.sv
// Remaining-shift down-counter: loaded with the distance on accept, flags the final pass.
module alu_seq_shift_cnt #(
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               dec_i,
    input  logic [SHAMT_W-1:0] amt_i,
    output logic               last_o
);

    logic [SHAMT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= amt_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - SHAMT_W'(1);
        end
    end

    assign last_o = (cnt_q == SHAMT_W'(1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences 64-bit add/sub and multi-bit shifts as single-cycle passes through a 32-bit ALU.
// One command in flight; the response is held until rsp_ready.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [2*DATA_W-1:0] cmd_a,
    input  logic [2*DATA_W-1:0] cmd_b,
    input  logic [SHAMT_W-1:0]  cmd_amt,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*DATA_W-1:0] rsp_data,
    output logic                rsp_cout,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [3:0]          alu_s,
    output logic                alu_cin,
    output logic                alu_dl,
    output logic                alu_dr,
    input  logic [DATA_W-1:0]   alu_f,
    input  logic                alu_cout
);

    state_e              state_q;
    logic [2:0]          op_q;
    logic [2*DATA_W-1:0] a_q;
    logic [2*DATA_W-1:0] b_q;
    logic [2*DATA_W-1:0] res_q;
    logic                cout_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic                cmd_fire;
    logic                cnt_last;

    assign cmd_fire = cmd_valid && cmd_ready_q;

    alu_seq_shift_cnt #(.SHAMT_W(SHAMT_W)) u_shift_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (cmd_fire),
        .dec_i  (state_q == ST_SHIFT),
        .amt_i  (cmd_amt),
        .last_o (cnt_last)
    );

    // res_q doubles as the shift working register and cout_q as the inter-word carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        op_q        <= cmd_op;
                        a_q         <= cmd_a;
                        b_q         <= cmd_b;
                        cmd_ready_q <= 1'b0;
                        res_q       <= {{DATA_W{1'b0}}, cmd_a[DATA_W-1:0]};
                        cout_q      <= 1'b0;
                        if ((cmd_op == OP_ADD64) || (cmd_op == OP_SUB64)) begin
                            state_q <= ST_LO;
                        end else if (is_shift(cmd_op) && (cmd_amt != '0)) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q     <= ST_DONE;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                ST_LO: begin
                    res_q[DATA_W-1:0] <= alu_f;
                    cout_q            <= alu_cout;
                    state_q           <= ST_HI;
                end
                ST_HI: begin
                    res_q[2*DATA_W-1:DATA_W] <= alu_f;
                    cout_q                   <= alu_cout;
                    state_q                  <= ST_DONE;
                    rsp_valid_q              <= 1'b1;
                end
                ST_SHIFT: begin
                    res_q[DATA_W-1:0] <= alu_f;
                    cout_q <= (op_q == OP_SHL) ? res_q[DATA_W-1] : res_q[0];
                    if (cnt_last) begin
                        state_q     <= ST_DONE;
                        rsp_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_s   = ALU_TRANSFER;
        alu_cin = 1'b0;
        alu_dl  = 1'b0;
        alu_dr  = 1'b0;
        case (state_q)
            ST_LO: begin
                alu_a   = a_q[DATA_W-1:0];
                alu_b   = b_q[DATA_W-1:0];
                alu_s   = (op_q == OP_SUB64) ? ALU_SUBM1 : ALU_ADD;
                alu_cin = (op_q == OP_SUB64);
            end
            ST_HI: begin
                alu_a   = a_q[2*DATA_W-1:DATA_W];
                alu_b   = b_q[2*DATA_W-1:DATA_W];
                alu_s   = (op_q == OP_SUB64) ? ALU_SUBM1 : ALU_ADD;
                alu_cin = cout_q;
            end
            ST_SHIFT: begin
                alu_a = res_q[DATA_W-1:0];
                if (op_q == OP_SHL) begin
                    alu_s = ALU_SHL;
                end else begin
                    alu_s  = ALU_SHR;
                    alu_dr = (op_q == OP_SHRA) ? res_q[DATA_W-1] : 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = res_q;
    assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized bench for alu_seq_ctrl driving a behavioural 32-bit ALU, checked against an arithmetic reference.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [63:0] cmd_a;
    logic [63:0] cmd_b;
    logic [4:0]  cmd_amt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_cout;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_s;
    logic        alu_cin;
    logic        alu_dl;
    logic        alu_dr;
    logic [31:0] alu_f;
    logic        alu_cout;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_amt   (cmd_amt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_cout  (rsp_cout),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_cin   (alu_cin),
        .alu_dl    (alu_dl),
        .alu_dr    (alu_dr),
        .alu_f     (alu_f),
        .alu_cout  (alu_cout)
    );

    // Combinational 32-bit ALU stand-in.
    always_comb begin
        alu_f    = '0;
        alu_cout = 1'b0;
        case (alu_s)
            4'b0000: alu_f = alu_a;
            4'b0001: {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {32'b0, alu_cin};
            4'b0010: {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, ~alu_b} + {32'b0, alu_cin};
            4'b1000: begin alu_f = {alu_dr, alu_a[31:1]}; alu_cout = alu_a[0]; end
            4'b1100: begin alu_f = {alu_a[30:0], alu_dl}; alu_cout = alu_a[31]; end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                             input int n, output logic [63:0] res, output logic cout, output int lat);
        logic [31:0] a32;
        logic [64:0] sum;
        a32 = a[31:0];
        res = {32'b0, a32};
        cout = 1'b0;
        lat = 1;
        if (op == 3'd0) begin
            sum = {1'b0, a} + {1'b0, b};
            res = sum[63:0]; cout = sum[64]; lat = 3;
        end else if (op == 3'd1) begin
            res = a - b; cout = (a >= b); lat = 3;
        end else if (op >= 3'd2 && op <= 3'd4 && n != 0) begin
            lat = n + 1;
            if (op == 3'd2) begin
                res = {32'b0, a32 << n}; cout = a32[32-n];
            end else if (op == 3'd3) begin
                res = {32'b0, a32 >> n}; cout = a32[n-1];
            end else begin
                res = {32'b0, 32'($signed(a32) >>> n)}; cout = a32[n-1];
            end
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           input int n, input int stall);
        logic [63:0] exp_res;
        logic        exp_cout;
        int          exp_lat;
        int          edges;
        logic        alu_used;
        logic [63:0] held;
        logic        held_c;
        ref_model(op, a, b, n, exp_res, exp_cout, exp_lat);
        @(negedge clk);
        chk("ready_before", {63'b0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_amt = 5'(n);
        @(posedge clk);
        edges = 1;
        alu_used = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_a = {$urandom, $urandom}; cmd_b = {$urandom, $urandom};
        while (!rsp_valid && edges < 100) begin
            if (alu_s != 4'b0000) alu_used = 1'b1;
            chk("ready_busy", {63'b0, cmd_ready}, 64'd0);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("latency", 64'(edges), 64'(exp_lat));
        chk("rsp_data", rsp_data, exp_res);
        chk("rsp_cout", {63'b0, rsp_cout}, {63'b0, exp_cout});
        if (exp_lat == 1) chk("pass_no_alu", {63'b0, alu_used}, 64'd0);
        held = rsp_data; held_c = rsp_cout;
        for (int i = 0; i < stall; i++) begin
            cmd_valid = 1'b1; cmd_op = 3'($urandom); cmd_a = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            chk("stall_data", rsp_data, held);
            chk("stall_cout", {63'b0, rsp_cout}, {63'b0, held_c});
            chk("stall_valid_ready", {62'b0, rsp_valid, cmd_ready}, 64'd2);
            chk("done_alu_idle", {28'b0, alu_s, alu_a}, 64'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("after_handshake", {62'b0, rsp_valid, cmd_ready}, 64'd1);
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_amt = '0;
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("reset_outputs", {60'b0, cmd_ready, rsp_valid, rsp_cout, alu_cin}, 64'd8);
        chk("reset_data", rsp_data, 64'd0);
        chk("reset_alu", {alu_s, alu_dl, alu_dr, alu_a, alu_b[25:0]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmd(3'd0, 64'h00000000_FFFFFFFF, 64'd1, 0, 0);
        run_cmd(3'd1, 64'd0, 64'd1, 0, 2);
        run_cmd(3'd1, 64'd5, 64'd3, 0, 0);
        run_cmd(3'd4, 64'h80000000, 64'd0, 31, 1);
        run_cmd(3'd2, 64'h80000001, 64'd0, 1, 0);
        run_cmd(3'd2, 64'h12345678, 64'd0, 0, 0);
        run_cmd(3'd7, 64'h12345678, 64'd0, 7, 0);
        run_cmd(3'd0, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 0, 10);

        for (int k = 0; k < 60; k++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rb = ra;
            run_cmd(3'($urandom_range(0, 7)), ra, rb, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
        end

        // Abort a long shift mid-flight.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 64'hF0F0F0F0; cmd_amt = 5'd20;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_flags", {62'b0, rsp_valid, cmd_ready}, 64'd1);
        chk("abort_alu", {28'b0, alu_s, alu_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            repeat (30) begin
                @(negedge clk);
                if (rsp_valid) seen = 1'b1;
            end
            chk("abort_no_rsp", {63'b0, seen}, 64'd0);
        end
        run_cmd(3'd1, 64'd100, 64'd7, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
